// File: rtl/gaussian_conv.sv
// Separable fixed-point Gaussian blur: raster-scans a source SRAM and writes one rounded K x K result per pixel.
// K*K+2 cycles per pixel; no backpressure, both SRAMs must accept one access every cycle.
module gaussian_conv #(
  parameter int MAX_KERNAL  = 5,
  parameter int X_MAX       = 16,
  parameter int Y_MAX       = 16,
  parameter int PIXEL_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     new_trans,
  input  logic [$clog2(X_MAX)-1:0] max_x,
  input  logic [$clog2(Y_MAX)-1:0] max_y,
  input  logic [7:0]               kernel_size,
  input  logic [2:0]               sigma,
  output logic [$clog2(X_MAX):0]   x_addr_img,
  output logic [$clog2(Y_MAX):0]   y_addr_img,
  output logic                     ren_img,
  input  logic [PIXEL_DEPTH-1:0]   rdat_img,
  output logic [$clog2(X_MAX):0]   x_addr_conv,
  output logic [$clog2(Y_MAX):0]   y_addr_conv,
  output logic                     wen_conv,
  output logic [PIXEL_DEPTH-1:0]   wdat_conv,
  output logic                     conv_done
);
  localparam int XW  = $clog2(X_MAX);
  localparam int YW  = $clog2(Y_MAX);
  localparam int AXW = XW + 1;
  localparam int AYW = YW + 1;
  localparam int KW  = $clog2(MAX_KERNAL + 1);
  localparam int ACW = 17;
  localparam logic [ACW-1:0] PMAX = ACW'((1 << PIXEL_DEPTH) - 1);

  typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

  state_t           state;
  logic [2:0]       sig;
  logic [KW-1:0]    ksz, kx, ky;
  logic [XW-1:0]    mx, px;
  logic [YW-1:0]    my, py;
  logic [ACW-1:0]   acc;
  logic [8:0]       pend_w;
  logic             pend_vld;

  // 1-D tap weights; every set sums to 16 so the 2-D product sums to 256.
  function automatic logic [4:0] w1(input logic [KW-1:0] k, input logic [2:0] s, input logic [KW-1:0] i);
    logic [4:0] w;
    w = 5'd0;
    if (k == KW'(1)) begin
      w = 5'd16;
    end else if (k == KW'(3)) begin
      case (s)
        3'd0:    w = (i == KW'(1)) ? 5'd16 : 5'd0;
        3'd1:    w = (i == KW'(1)) ? 5'd8  : 5'd4;
        default: w = (i == KW'(1)) ? 5'd6  : 5'd5;
      endcase
    end else begin
      case (s)
        3'd0:    w = (i == KW'(2)) ? 5'd16 : 5'd0;
        3'd1:    w = (i == KW'(2)) ? 5'd6 : ((i == KW'(0) || i == KW'(4)) ? 5'd1 : 5'd4);
        3'd2:    w = (i == KW'(0) || i == KW'(4)) ? 5'd2 : 5'd4;
        default: w = (i == KW'(2)) ? 5'd4 : 5'd3;
      endcase
    end
    return w;
  endfunction

  function automatic int clamp(input int c, input int hi);
    if (c < 0)  return 0;
    if (c > hi) return hi;
    return c;
  endfunction

  logic [KW-1:0]          k_dec, half, k_end, nkx, nky;
  logic                   tap_last, row_end, pix_last;
  logic [XW-1:0]          npx;
  logic [YW-1:0]          npy;
  logic [AXW-1:0]         rd_x, nxt_x;
  logic [AYW-1:0]         rd_y, nxt_y;
  logic [8:0]             tap_w;
  logic [ACW-1:0]         prod, acc_nxt, rnd, shifted;
  logic [PIXEL_DEPTH-1:0] res;

  always_comb begin
    k_dec    = (kernel_size == 8'd1) ? KW'(1) : ((kernel_size == 8'd3) ? KW'(3) : KW'(MAX_KERNAL));
    half     = ksz >> 1;
    k_end    = ksz - 1'b1;
    tap_last = (kx == k_end) && (ky == k_end);
    nkx      = (kx == k_end) ? '0 : kx + 1'b1;
    nky      = (kx == k_end) ? ky + 1'b1 : ky;
    row_end  = (px == mx);
    pix_last = row_end && (py == my);
    npx      = row_end ? '0 : px + 1'b1;
    npy      = row_end ? py + 1'b1 : py;
    // Addresses are registered, so they are formed from the tap that will be issued next.
    rd_x     = AXW'(clamp(int'(px) + int'(nkx) - int'(half), int'(mx)));
    rd_y     = AYW'(clamp(int'(py) + int'(nky) - int'(half), int'(my)));
    nxt_x    = AXW'(clamp(int'(npx) - int'(half), int'(mx)));
    nxt_y    = AYW'(clamp(int'(npy) - int'(half), int'(my)));
    tap_w    = 9'(w1(ksz, sig, ky)) * 9'(w1(ksz, sig, kx));
    prod     = ACW'(pend_w) * ACW'(rdat_img);
    acc_nxt  = acc + (pend_vld ? prod : '0);
    rnd      = acc_nxt + ACW'(128);
    shifted  = rnd >> 8;
    res      = (shifted > PMAX) ? PMAX[PIXEL_DEPTH-1:0] : shifted[PIXEL_DEPTH-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      sig         <= '0;
      ksz         <= '0;
      mx          <= '0;
      my          <= '0;
      px          <= '0;
      py          <= '0;
      kx          <= '0;
      ky          <= '0;
      acc         <= '0;
      pend_w      <= '0;
      pend_vld    <= 1'b0;
      x_addr_img  <= '0;
      y_addr_img  <= '0;
      ren_img     <= 1'b0;
      x_addr_conv <= '0;
      y_addr_conv <= '0;
      wen_conv    <= 1'b0;
      wdat_conv   <= '0;
      conv_done   <= 1'b0;
    end else begin
      // Read data for the tap issued last cycle arrives now and is folded in here.
      acc      <= acc_nxt;
      pend_vld <= (state == READ);
      pend_w   <= tap_w;
      ren_img  <= 1'b0;
      wen_conv <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (new_trans) begin
            sig        <= sigma;
            ksz        <= k_dec;
            mx         <= max_x;
            my         <= max_y;
            px         <= '0;
            py         <= '0;
            kx         <= '0;
            ky         <= '0;
            x_addr_img <= '0;
            y_addr_img <= '0;
            ren_img    <= 1'b1;
            conv_done  <= 1'b0;
            state      <= READ;
          end
        end
        READ: begin
          if (tap_last) begin
            state <= LAST;
          end else begin
            kx         <= nkx;
            ky         <= nky;
            x_addr_img <= rd_x;
            y_addr_img <= rd_y;
            ren_img    <= 1'b1;
          end
        end
        LAST: begin
          wen_conv    <= 1'b1;
          wdat_conv   <= res;
          x_addr_conv <= AXW'(px);
          y_addr_conv <= AYW'(py);
          state       <= WRITE;
        end
        WRITE: begin
          acc <= '0;
          kx  <= '0;
          ky  <= '0;
          if (pix_last) begin
            conv_done <= 1'b1;
            state     <= DONE;
          end else begin
            px         <= npx;
            py         <= npy;
            x_addr_img <= nxt_x;
            y_addr_img <= nxt_y;
            ren_img    <= 1'b1;
            state      <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gaussian_conv.sv
// Directed bench for gaussian_conv: SRAM model, reference blur and an in-order write scoreboard.
module tb_gaussian_conv;
  logic       clk = 1'b0;
  logic       n_rst, new_trans;
  logic [3:0] max_x, max_y;
  logic [7:0] kernel_size;
  logic [2:0] sigma;
  logic [4:0] x_addr_img, y_addr_img, x_addr_conv, y_addr_conv;
  logic       ren_img, wen_conv, conv_done;
  logic [7:0] rdat_img, wdat_conv;

  always #5 clk = ~clk;

  gaussian_conv dut (
    .clk(clk), .n_rst(n_rst), .new_trans(new_trans), .max_x(max_x), .max_y(max_y),
    .kernel_size(kernel_size), .sigma(sigma), .x_addr_img(x_addr_img), .y_addr_img(y_addr_img),
    .ren_img(ren_img), .rdat_img(rdat_img), .x_addr_conv(x_addr_conv), .y_addr_conv(y_addr_conv),
    .wen_conv(wen_conv), .wdat_conv(wdat_conv), .conv_done(conv_done)
  );

  typedef struct packed {
    logic [4:0] y;
    logic [4:0] x;
    logic [7:0] d;
  } wr_t;

  logic [7:0] img     [16][16];
  logic [7:0] out_img [16][16];
  wr_t        sb[$];
  int         checks = 0;
  int         failures = 0;
  int         t5 [4][5] = '{'{0, 0, 16, 0, 0}, '{1, 4, 6, 4, 1}, '{2, 4, 4, 4, 2}, '{3, 3, 4, 3, 3}};
  int         t3 [3][3] = '{'{0, 16, 0}, '{4, 8, 4}, '{5, 6, 5}};

  // Source SRAM: one-cycle read latency, junk on the bus when no read was issued.
  always @(posedge clk) begin
    if (ren_img) rdat_img <= img[y_addr_img[3:0]][x_addr_img[3:0]];
    else         rdat_img <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wt(input int k, input int s, input int i);
    if (k == 1) return 16;
    if (k == 3) return t3[(s > 2) ? 2 : s][i];
    return t5[(s > 3) ? 3 : s][i];
  endfunction

  function automatic int ref_px(input int x, input int y, input int k, input int s, input int mx, input int my);
    int h, a, cx, cy;
    h = k / 2;
    a = 0;
    for (int j = 0; j < k; j++) begin
      for (int i = 0; i < k; i++) begin
        cy = y + j - h;
        cx = x + i - h;
        cy = (cy < 0) ? 0 : ((cy > my) ? my : cy);
        cx = (cx < 0) ? 0 : ((cx > mx) ? mx : cx);
        a += wt(k, s, j) * wt(k, s, i) * int'(img[cy][cx]);
      end
    end
    a = (a + 128) >> 8;
    return (a > 255) ? 255 : a;
  endfunction

  task automatic run_scan(input int ks, input int s, input int mx, input int my, input int pulse_at,
                          output int cycles, output int wens, output logic done1);
    int  k, limit;
    wr_t e;
    k = (ks == 1) ? 1 : ((ks == 3) ? 3 : 5);
    for (int y = 0; y <= my; y++) begin
      for (int x = 0; x <= mx; x++) begin
        e.y = 5'(y);
        e.x = 5'(x);
        e.d = 8'(ref_px(x, y, k, s, mx, my));
        sb.push_back(e);
      end
    end
    kernel_size = 8'(ks);
    sigma       = 3'(s);
    max_x       = 4'(mx);
    max_y       = 4'(my);
    limit       = (mx + 1) * (my + 1) * (k * k + 2) + 20;
    cycles      = 0;
    wens        = 0;
    done1       = 1'b1;
    @(negedge clk);
    new_trans = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      new_trans = (cycles == pulse_at);
      if (cycles == 1) done1 = conv_done;
      if (wen_conv) begin
        wens++;
        out_img[y_addr_conv[3:0]][x_addr_conv[3:0]] = wdat_conv;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_pix", {y_addr_conv, x_addr_conv, wdat_conv}, e);
        end
      end
    end while (!conv_done && cycles < limit);
    new_trans = 1'b0;
  endtask

  initial begin
    int   cyc, wens, rc;
    logic d1;
    n_rst = 1'b0; new_trans = 1'b0; max_x = '0; max_y = '0; kernel_size = 8'd5; sigma = '0;
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) out_img[y][x] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren", ren_img, 0);
    chk("rst_wen", wen_conv, 0);
    chk("rst_done", conv_done, 0);
    chk("rst_addr", {y_addr_img, x_addr_img}, 0);
    chk("rst_wdat", wdat_conv, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Uniform image, sigma 3, K=5
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'd100;
    run_scan(5, 3, 15, 15, 0, cyc, wens, d1);
    chk("uni_cycles", cyc, 6913);
    chk("uni_wens", wens, 256);
    chk("uni_sb_left", sb.size(), 0);
    chk("uni_pix_5_7", out_img[7][5], 100);
    repeat (5) @(posedge clk);
    #1;
    chk("uni_done_held", conv_done, 1);

    // Identity (sigma 0) restarted straight from DONE
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'($urandom);
    run_scan(5, 0, 15, 15, 0, cyc, wens, d1);
    chk("id_done_drop", d1, 0);
    chk("id_cycles", cyc, 6913);
    chk("id_wens", wens, 256);
    chk("id_pix_9_3", out_img[3][9], img[3][9]);

    // Impulse, sigma 1; kernel_size 9 must fall back to 5 taps
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'd0;
    img[8][8] = 8'd255;
    run_scan(9, 1, 15, 15, 0, cyc, wens, d1);
    chk("imp_cycles", cyc, 6913);
    chk("imp_8_8", out_img[8][8], 36);
    chk("imp_7_8", out_img[8][7], 24);
    chk("imp_6_6", out_img[6][6], 1);
    chk("imp_3_8", out_img[8][3], 0);

    // Corner clamp, sigma 1, K=3
    img[8][8] = 8'd0;
    img[0][0] = 8'd255;
    run_scan(3, 1, 15, 15, 0, cyc, wens, d1);
    chk("cor_cycles", cyc, 2817);
    chk("cor_0_0", out_img[0][0], 143);
    chk("cor_1_1", out_img[1][1], 16);
    chk("cor_2_2", out_img[2][2], 0);

    // new_trans mid-scan must not disturb a 6x4 K=3 scan
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'($urandom);
    run_scan(3, 2, 5, 3, 100, cyc, wens, d1);
    chk("mid_pulse_cycles", cyc, 265);
    chk("mid_pulse_wens", wens, 24);

    // 1-tap kernel restarted from DONE
    run_scan(1, 5, 15, 15, 0, cyc, wens, d1);
    chk("k1_done_drop", d1, 0);
    chk("k1_cycles", cyc, 769);
    chk("k1_sb_left", sb.size(), 0);

    // Reset while holding DONE
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("rst_in_done", conv_done, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Reset mid-scan at cycle 1000
    kernel_size = 8'd5; sigma = 3'd2; max_x = 4'd15; max_y = 4'd15;
    @(negedge clk);
    new_trans = 1'b1;
    @(posedge clk);
    #1;
    new_trans = 1'b0;
    repeat (999) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_ren", ren_img, 0);
    chk("mid_rst_wen", wen_conv, 0);
    chk("mid_rst_done", conv_done, 0);
    chk("mid_rst_addr", {y_addr_img, x_addr_img}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    rc = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ren_img || wen_conv) rc++;
    end
    chk("post_rst_idle", rc, 0);
    chk("post_rst_done", conv_done, 0);

    // Recovery scan after reset
    run_scan(3, 1, 3, 3, 0, cyc, wens, d1);
    chk("rec_cycles", cyc, 177);
    chk("rec_wens", wens, 16);
    chk("rec_sb_left", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gaussian_conv.md
# gaussian_conv

Streaming 2-D Gaussian blur engine for the ISP front end of the Oriented-FAST corner detector. On a start pulse it raster-scans a source image held in an external synchronous `sram_image` instance. For each output pixel it reads the K×K neighbourhood, applies a separable fixed-point Gaussian kernel selected by `sigma` and `kernel_size`, and writes the rounded result to a second `sram_image` instance. It then raises `conv_done`.

## Interface
- `MAX_KERNAL`, 5: largest supported kernel width (odd).
- `X_MAX`, 16: image width capacity.
- `Y_MAX`, 16: image height capacity.
- `PIXEL_DEPTH`, 8: bits per pixel.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: the block's single clock.
- `n_rst` in 1: asynchronous active-low reset.
- `new_trans` in 1: start pulse.
- `max_x` in $clog2(X_MAX): last column index, inclusive (15 → 16 columns).
- `max_y` in $clog2(Y_MAX): last row index, inclusive.
- `kernel_size` in 8: kernel width. 1 → 1-tap, 3 → 3-tap, any other value → `MAX_KERNAL` taps.
- `sigma` in 3: kernel strength select.
- `x_addr_img`, `y_addr_img` out $clog2(X_MAX)+1 / $clog2(Y_MAX)+1: source SRAM read address.
- `ren_img` out 1: source SRAM read enable.
- `rdat_img` in `PIXEL_DEPTH`: source read data, valid the cycle after `ren_img`.
- `x_addr_conv`, `y_addr_conv` out (same widths as the source address): result SRAM write address.
- `wen_conv` out 1: result write strobe.
- `wdat_conv` out `PIXEL_DEPTH`: result pixel.
- `conv_done` out 1: image complete.

## Operation
- **Parameter latch:** `sigma`, `kernel_size`, `max_x` and `max_y` are latched when `new_trans` is accepted.
- **1-D weights (each set sums to 16), 5-tap:**
  - sigma 0: [0,0,16,0,0]
  - sigma 1: [1,4,6,4,1]
  - sigma 2: [2,4,4,4,2]
  - sigma ≥3: [3,3,4,3,3]
- **1-D weights, 3-tap:**
  - sigma 0: [0,16,0]
  - sigma 1: [4,8,4]
  - sigma ≥2: [5,6,5]
- **1-D weights, 1-tap:** [16].
- **2-D weight:** w(ky,kx) = w1[ky]·w1[kx], so the 2-D kernel sums to 256.
- **Output value:** out = (Σ w·p + 128) >> 8, clipped to 255. Use a 17-bit accumulator; nothing in this path is signed.
- **Borders:** replicate the edge pixel. The tap coordinate is clamped to [0, max_x] and [0, max_y].
- **Scan order:** output pixels in raster order (y outer, x inner). Taps within a pixel run ky from −K/2 to +K/2 (outer) and kx from −K/2 to +K/2 (inner).
- **FSM:**
  - IDLE → READ on `new_trans`.
  - READ lasts K² cycles, one tap per cycle with `ren_img`=1. The data returned for tap n−1 is accumulated during tap n.
  - LAST (1 cycle): `ren_img`=0; accumulate the final tap.
  - WRITE (1 cycle): `wen_conv`=1, with `wdat_conv` and the address equal to the current pixel; clear the accumulator.
  - From WRITE, go to READ for the next pixel, or to DONE after pixel (max_x, max_y).
  - DONE: `conv_done`=1, held. `new_trans` in DONE restarts the scan (DONE → READ, `conv_done` drops).
- `new_trans` is ignored in READ, LAST and WRITE.
- **Reset (at any time, including mid-scan):** all outputs to 0, FSM to IDLE, accumulator cleared.

## Timing
- `new_trans` is sampled at a rising edge. The first `ren_img` is asserted in the following cycle.
- **Per pixel:** K²+2 cycles. K=5 → 27 cycles; K=3 → 11; K=1 → 3.
- **Full image:** (max_x+1)(max_y+1)(K²+2) cycles. A 16×16 image with K=5 takes 6912 cycles.
- `conv_done` rises one cycle after the final `wen_conv`.
- The SRAM contract is a synchronous read with 1-cycle latency. `rdat_img` is ignored when no read was issued in the previous cycle.
- `wen_conv` is a single-cycle pulse per pixel. Address and data are stable in that same cycle.

## Test plan
- **Uniform image:** 16×16 all 100, sigma 3, K=5 → every written pixel is 100; `conv_done` rises exactly 6913 cycles after `new_trans` is sampled (6912 scan cycles plus the 1-cycle delay after the final `wen_conv`).
- **Identity:** sigma 0, K=5, arbitrary image → output equals input at every (x,y); 256 `wen_conv` pulses in raster order.
- **Impulse:** (8,8)=255, zeros elsewhere, sigma 1, K=5 → out(8,8)=36, out(7,8)=24, out(6,6)=1, out(3,8)=0.
- **Corner clamp:** only (0,0)=255, sigma 1, K=3 → out(0,0)=143, out(1,1)=16, out(2,2)=0.
- **Control:**
  - `new_trans` pulsed mid-scan → ignored, and total cycle count unchanged.
  - `new_trans` in DONE → `conv_done` drops and a fresh scan runs.
- **Reset mid-scan:** assert `n_rst`=0 at cycle 1000 → `ren_img`, `wen_conv` and `conv_done` read 0 immediately. After release the block stays IDLE until `new_trans`.
